// File: rtl/mag_frame_stats.sv
// mag_frame_stats: gathers FRAME_LEN unsigned magnitudes over a valid/ready
// input, then presents their sum and maximum as one held result beat.
// A frame is dropped by flush or reset; nothing partial is ever emitted.
module mag_frame_stats #(
   parameter int DATA_W    = 4,
   parameter int FRAME_LEN = 8,
   parameter int SUM_W     = DATA_W + $clog2(FRAME_LEN),
   parameter int CNT_W     = $clog2(FRAME_LEN)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [DATA_W-1:0] mag_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [SUM_W-1:0]  sum_out,
   output logic [DATA_W-1:0] max_out,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [SUM_W-1:0]  acc_sum_reg, acc_sum_next;
   logic [DATA_W-1:0] acc_max_reg, acc_max_next;
   logic [SUM_W-1:0]  sum_out_reg, sum_out_next;
   logic [DATA_W-1:0] max_out_reg, max_out_next;

   // Running totals including the sample on mag_in this cycle.
   logic [SUM_W-1:0]  sum_incl;
   logic [DATA_W-1:0] max_incl;
   logic              last_sample;

   assign sum_incl    = acc_sum_reg + SUM_W'(mag_in);
   assign max_incl    = (mag_in > acc_max_reg) ? mag_in : acc_max_reg;
   assign last_sample = (count_reg == CNT_W'(FRAME_LEN - 1));

   // Handshake signals follow the state register directly, so both are glitch-free.
   assign in_ready  = (state_reg == ACC);
   assign out_valid = (state_reg == HOLD);
   assign sum_out   = sum_out_reg;
   assign max_out   = max_out_reg;

   // Next-state and datapath update; flush overrides any accept or consume.
   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      acc_sum_next = acc_sum_reg;
      acc_max_next = acc_max_reg;
      sum_out_next = sum_out_reg;
      max_out_next = max_out_reg;

      case (state_reg)
         ACC: begin
            if (in_valid) begin
               if (last_sample) begin
                  sum_out_next = sum_incl;
                  max_out_next = max_incl;
                  acc_sum_next = '0;
                  acc_max_next = '0;
                  count_next   = '0;
                  state_next   = HOLD;
               end else begin
                  acc_sum_next = sum_incl;
                  acc_max_next = max_incl;
                  count_next   = count_reg + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = ACC;
            end
         end
         default: begin
            state_next = ACC;
         end
      endcase

      // Result registers keep their last value on flush; out_valid drops.
      if (flush) begin
         state_next   = ACC;
         count_next   = '0;
         acc_sum_next = '0;
         acc_max_next = '0;
         sum_out_next = sum_out_reg;
         max_out_next = max_out_reg;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ACC;
         count_reg   <= '0;
         acc_sum_reg <= '0;
         acc_max_reg <= '0;
         sum_out_reg <= '0;
         max_out_reg <= '0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         acc_sum_reg <= acc_sum_next;
         acc_max_reg <= acc_max_next;
         sum_out_reg <= sum_out_next;
         max_out_reg <= max_out_next;
      end
   end

endmodule

// File: tb/tb_mag_frame_stats.sv
// Bench for mag_frame_stats: directed frames with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based model.
module tb_mag_frame_stats;

   localparam int DATA_W    = 4;
   localparam int FRAME_LEN = 8;
   localparam int SUM_W     = DATA_W + $clog2(FRAME_LEN);

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic [DATA_W-1:0] mag_in;
   logic              in_valid;
   logic              in_ready;
   logic [SUM_W-1:0]  sum_out;
   logic [DATA_W-1:0] max_out;
   logic              out_valid;
   logic              out_ready;

   int checks = 0;
   int errors = 0;

   mag_frame_stats #(
      .DATA_W   (DATA_W),
      .FRAME_LEN(FRAME_LEN)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .mag_in   (mag_in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .sum_out  (sum_out),
      .max_out  (max_out),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the current frame is a queue of accepted samples;
   // a full queue becomes a held result until consumed, flushed or reset.
   int m_q[$];
   bit m_valid = 0;
   int m_sum   = 0;
   int m_max   = 0;

   // Advance the model on each edge with the inputs seen there, then compare outputs.
   always begin
      @(posedge clk);
      if (!rst_n) begin
         m_q.delete();
         m_valid = 0;
         m_sum   = 0;
         m_max   = 0;
      end else if (flush) begin
         m_q.delete();
         m_valid = 0;
      end else if (m_valid) begin
         if (out_ready) m_valid = 0;
      end else if (in_valid) begin
         m_q.push_back(int'(mag_in));
         if (m_q.size() == FRAME_LEN) begin
            m_sum = 0;
            m_max = 0;
            foreach (m_q[i]) begin
               m_sum += m_q[i];
               if (m_q[i] > m_max) m_max = m_q[i];
            end
            m_q.delete();
            m_valid = 1;
         end
      end
      #1;
      chk("in_ready",  int'(in_ready),  int'(!m_valid));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("sum_out",   int'(sum_out),   m_sum);
      chk("max_out",   int'(max_out),   m_max);
   end

   // Offer one sample and return at the falling edge after it was accepted.
   task automatic send(input int v);
      bit done;
      done     = 0;
      mag_in   = DATA_W'(v);
      in_valid = 1'b1;
      for (int t = 0; t < 64 && !done; t++) begin
         done = in_ready;
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=no_accept expected=accept value=%0d", v);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input string name);
      bit seen;
      seen = 0;
      for (int t = 0; t < 32 && !seen; t++) begin
         if (out_valid) seen = 1;
         else @(negedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=out_valid_low expected=out_valid_high", name);
      end
   endtask

   initial begin
      int seq3[8];
      seq3 = '{3, 0, 7, 2, 7, 1, 0, 5};
      rst_n     = 1'b0;
      flush     = 1'b0;
      mag_in    = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_sum", int'(sum_out), 0);
      chk("reset_out_valid", int'(out_valid), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);

      // Test 1: samples 1..8 back-to-back
      for (int i = 1; i <= 8; i++) send(i);
      chk("t1_out_valid", int'(out_valid), 1);
      chk("t1_in_ready_low", int'(in_ready), 0);
      chk("t1_sum", int'(sum_out), 36);
      chk("t1_max", int'(max_out), 8);
      @(negedge clk);
      chk("t1_in_ready_back", int'(in_ready), 1);
      chk("t1_consumed", int'(out_valid), 0);
      $display("test1 frame 1..8 done sum=%0d max=%0d", sum_out, max_out);

      // Test 2: full-scale samples
      for (int i = 0; i < 8; i++) send(15);
      wait_valid("t2");
      chk("t2_sum", int'(sum_out), 120);
      chk("t2_max", int'(max_out), 15);
      @(negedge clk);
      $display("test2 full scale done");

      // Test 3: sequence with random gaps
      for (int i = 0; i < 8; i++) begin
         idle($urandom_range(0, 3));
         send(seq3[i]);
      end
      wait_valid("t3");
      chk("t3_sum", int'(sum_out), 25);
      chk("t3_max", int'(max_out), 7);
      @(negedge clk);
      $display("test3 gapped frame done");

      // Test 4: held result with back-pressure while input keeps offering
      out_ready = 1'b0;
      for (int i = 4; i <= 11; i++) send(i);
      wait_valid("t4");
      mag_in   = 4'd3;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("t4_hold_in_ready", int'(in_ready), 0);
         chk("t4_hold_valid", int'(out_valid), 1);
         chk("t4_hold_sum", int'(sum_out), 60);
         chk("t4_hold_max", int'(max_out), 11);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 8; i++) send(1);
      wait_valid("t4b");
      chk("t4_fresh_sum", int'(sum_out), 8);
      chk("t4_fresh_max", int'(max_out), 1);
      @(negedge clk);
      $display("test4 back-pressure done");

      // Test 5: flush mid-frame with a simultaneous sample
      for (int i = 0; i < 4; i++) send(6);
      flush    = 1'b1;
      in_valid = 1'b1;
      mag_in   = 4'd6;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) send(2);
      wait_valid("t5");
      chk("t5_sum", int'(sum_out), 16);
      chk("t5_max", int'(max_out), 2);
      @(negedge clk);
      $display("test5 flush done");

      // Test 6: reset mid-frame and during hold
      for (int i = 0; i < 5; i++) send(9);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("t6_rst_sum", int'(sum_out), 0);
      chk("t6_rst_max", int'(max_out), 0);
      chk("t6_rst_valid", int'(out_valid), 0);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(5);
      wait_valid("t6");
      chk("t6_frame_sum", int'(sum_out), 40);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      chk("t6_hold_rst_valid", int'(out_valid), 0);
      chk("t6_hold_rst_sum", int'(sum_out), 0);
      for (int i = 0; i < 8; i++) send(i + 7);
      wait_valid("t6b");
      chk("t6_after_sum", int'(sum_out), 84);
      chk("t6_after_max", int'(max_out), 14);
      @(negedge clk);
      $display("test6 reset done");

      // Randomized traffic with back-pressure, flushes and resets
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         mag_in    = DATA_W'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 59) == 0);
         rst_n     = ($urandom_range(0, 149) != 0);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      $display("random phase done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
